// File: rtl/image_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// image_buffer_arbiter
//
// Double-buffered image store arbiter. A single-port byte RAM holds two image
// buffers of BUF_SIZE bytes each. The writer fills the back buffer while the
// reader fetches from the front buffer. A swap requested by the writer is
// taken on the reader's next frame boundary.
//
// Accesses are serialised by a small FSM that samples requests only in idle.
// When both requesters ask in the same idle cycle, the grant alternates. All
// outputs come straight from flops.
//
// Parameters:
//   IMAGE_BUF_X  image width in pixels
//   IMAGE_BUF_Y  image height in pixels
//   BUF_SIZE     derived bytes per buffer (IMAGE_BUF_X * IMAGE_BUF_Y * 2)
//
// Ports:
//   clk           sole clock, rising edge
//   reset         asynchronous active-low reset
//   wr_req        writer request, held until wr_ready
//   wr_addr       writer byte address within the back buffer
//   wr_data       writer byte
//   wr_ready      one-cycle write-committed pulse
//   rd_req        reader request, held until rd_valid
//   rd_addr       reader byte address within the front buffer
//   rd_data       read byte, valid while rd_valid
//   rd_valid      one-cycle read-data pulse
//   swap_req      writer frame-complete pulse
//   frame_end     reader frame-boundary pulse
//   front_buf     index of the buffer currently being read
//   swap_pending  swap requested but not yet taken
//   swap_done     one-cycle pulse when the buffers swap
//   ram_en        RAM access enable
//   ram_we        RAM write enable
//   ram_addr      RAM byte address (bank offset plus in-buffer address)
//   ram_wdata     RAM write data
//   ram_rdata     RAM read data, one cycle after ram_en
// ---------------------------------------------------------------------------
module image_buffer_arbiter #(
    parameter int unsigned IMAGE_BUF_X = 4,
    parameter int unsigned IMAGE_BUF_Y = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        swap_req,
    input  logic        frame_end,
    output logic        front_buf,
    output logic        swap_pending,
    output logic        swap_done,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    localparam int unsigned BUF_SIZE   = IMAGE_BUF_X * IMAGE_BUF_Y * 2;
    localparam int unsigned AW         = $clog2(BUF_SIZE);
    localparam logic [31:0] BUF_SIZE_W = 32'(BUF_SIZE);

    // Grant history encoding.
    localparam logic GrantWr = 1'b0;
    localparam logic GrantRd = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StRdata
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        front_buf_q, front_buf_d;
    logic        swap_pending_q, swap_pending_d;
    logic        swap_done_q, swap_done_d;
    logic        wr_ready_q, wr_ready_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_oob_q, rd_oob_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_we_q, ram_we_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_wdata_q, ram_wdata_d;

    logic        swap_take;
    logic        grant_wr;
    logic        grant_rd;
    logic        wr_in_range;
    logic        rd_in_range;
    logic [31:0] wr_offset;
    logic [31:0] rd_offset;
    logic [31:0] wr_bank_base;
    logic [31:0] rd_bank_base;

    // -----------------------------------------------------------------------
    // Buffer swap control. Runs independently of the access FSM; an access
    // already in flight keeps the address it latched at grant time.
    // -----------------------------------------------------------------------
    always_comb begin
        swap_take      = frame_end && (swap_pending_q || swap_req);
        front_buf_d    = front_buf_q;
        swap_pending_d = swap_pending_q;
        swap_done_d    = 1'b0;

        if (swap_take) begin
            front_buf_d    = ~front_buf_q;
            swap_pending_d = 1'b0;
            swap_done_d    = 1'b1;
        end else if (swap_req) begin
            swap_pending_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Address generation. Only the in-buffer bits of the requester address
    // are used; the bank offset is added at full width. A grant on the same
    // edge as a swap already targets the new bank arrangement.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_in_range  = (wr_addr < BUF_SIZE_W);
        rd_in_range  = (rd_addr < BUF_SIZE_W);
        wr_offset    = 32'(wr_addr[AW-1:0]);
        rd_offset    = 32'(rd_addr[AW-1:0]);
        // Writer always targets the back buffer, reader the front buffer.
        wr_bank_base = front_buf_d ? 32'd0 : BUF_SIZE_W;
        rd_bank_base = front_buf_d ? BUF_SIZE_W : 32'd0;
    end

    // -----------------------------------------------------------------------
    // Arbitration: on a tie, the requester not granted last time wins.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_wr = wr_req && (!rd_req || (last_grant_q == GrantRd));
        grant_rd = rd_req && !grant_wr;
    end

    // -----------------------------------------------------------------------
    // Access FSM next-state and registered-output logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_ready_d   = 1'b0;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        rd_oob_d     = rd_oob_q;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    state_d      = StWrite;
                    last_grant_d = GrantWr;
                    // Out-of-range writes are dropped but still acknowledged.
                    ram_en_d     = wr_in_range;
                    ram_we_d     = wr_in_range;
                    ram_addr_d   = wr_bank_base + wr_offset;
                    ram_wdata_d  = wr_data;
                    wr_ready_d   = 1'b1;
                end else if (grant_rd) begin
                    state_d      = StRead;
                    last_grant_d = GrantRd;
                    ram_en_d     = rd_in_range;
                    ram_we_d     = 1'b0;
                    ram_addr_d   = rd_bank_base + rd_offset;
                    rd_oob_d     = !rd_in_range;
                end
            end

            StWrite: begin
                state_d = StIdle;
            end

            // RAM latches the address at the end of this cycle.
            StRead: begin
                state_d = StRdata;
            end

            // RAM data is valid during this cycle; capture it.
            StRdata: begin
                state_d    = StIdle;
                rd_valid_d = 1'b1;
                rd_data_d  = rd_oob_q ? 8'h00 : ram_rdata;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            last_grant_q   <= GrantWr;
            front_buf_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            wr_ready_q     <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= 8'h00;
            rd_oob_q       <= 1'b0;
            ram_en_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_addr_q     <= 32'd0;
            ram_wdata_q    <= 8'h00;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            front_buf_q    <= front_buf_d;
            swap_pending_q <= swap_pending_d;
            swap_done_q    <= swap_done_d;
            wr_ready_q     <= wr_ready_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            rd_oob_q       <= rd_oob_d;
            ram_en_q       <= ram_en_d;
            ram_we_q       <= ram_we_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs.
    // -----------------------------------------------------------------------
    assign wr_ready     = wr_ready_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign front_buf    = front_buf_q;
    assign swap_pending = swap_pending_q;
    assign swap_done    = swap_done_q;
    assign ram_en       = ram_en_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;

endmodule

// File: doc/image_buffer_arbiter.md
IMAGE_BUFFER_ARBITER -- requirements
Module: image_buffer_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- IMAGE_BUF_X, 4, image width in pixels.
- IMAGE_BUF_Y, 3, image height in pixels.
- BUF_SIZE = IMAGE_BUF_X*IMAGE_BUF_Y*2 (derived, not overridable), bytes per buffer.

REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports, one per line:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_req  in  1  writer request, held until wr_ready.
- wr_addr  in  32  writer byte address within buffer.
- wr_data  in  8  writer byte.
- wr_ready  out  1  one-cycle write-committed pulse.
- rd_req  in  1  reader request, held until rd_valid.
- rd_addr  in  32  reader byte address within buffer.
- rd_data  out  8  read byte, valid while rd_valid.
- rd_valid  out  1  one-cycle read-data pulse.
- swap_req  in  1  writer frame-complete pulse.
- frame_end  in  1  reader frame-boundary pulse.
- front_buf  out  1  buffer currently read.
- swap_pending  out  1  swap requested, not yet taken.
- swap_done  out  1  one-cycle pulse on buffer swap.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM byte address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, one-cycle latency after ram_en.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 FSM states: IDLE, WRITE, READ, RDATA; requests are sampled only in IDLE.
REQ-005 IDLE with only wr_req: next state WRITE; IDLE with only rd_req: next state READ; neither: stay IDLE.
REQ-006 Both requests in IDLE: grant the requester not granted last (last_grant register, reset = writer, so reader wins first tie).
REQ-007 WRITE (one cycle): ram_en=1, ram_we=1, ram_addr=(~front_buf)*BUF_SIZE+wr_addr, ram_wdata=wr_data, wr_ready=1; next IDLE.
REQ-008 READ (one cycle): ram_en=1, ram_we=0, ram_addr=front_buf*BUF_SIZE+rd_addr; next RDATA.
REQ-009 RDATA: capture ram_rdata into rd_data, rd_valid=1 in the following cycle; next IDLE.
REQ-010 Latency: wr_ready 1 cycle after sampling edge; rd_valid 3 cycles after sampling edge.
REQ-011 Requesters SHALL drop req in the cycle after ready/valid; a req still high when IDLE is re-entered is a new request.
REQ-012 Address >= BUF_SIZE: write suppressed (ram_en=0) but wr_ready still pulses; read suppressed, rd_data=8'h00, rd_valid still pulses with normal latency.
REQ-013 Only the lower $clog2(BUF_SIZE) address bits feed ram_addr; the bank offset is added at full 32-bit width, no wrap.
REQ-014 swap_req sets swap_pending; swap_req while already pending has no further effect.
REQ-015 frame_end with swap_pending (or with swap_req in the same cycle): toggle front_buf, clear swap_pending, pulse swap_done, in any FSM state.
REQ-016 An access already in WRITE/READ/RDATA at a swap completes on its latched ram_addr; the next grant uses the new bank.
REQ-017 frame_end without a pending swap: no effect.

Reset
REQ-018 reset low SHALL asynchronously force: state=IDLE, last_grant=writer, front_buf=0, swap_pending=0, swap_done=0, wr_ready=0, rd_valid=0, rd_data=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-019 Reset mid-access SHALL abort with no ready/valid pulse; the first request after release is sampled on the first rising edge with reset high.

Verification
REQ-020 Write wr_addr=5, wr_data=8'hA5 after reset -> one cycle with ram_en=1, ram_we=1, ram_addr=BUF_SIZE+5=29, ram_wdata=A5; wr_ready pulses once.
REQ-021 Read rd_addr=7, ram_rdata model returns 8'h3C -> ram_addr=7, ram_we=0; rd_valid with rd_data=3C exactly 3 cycles after sampling.
REQ-022 wr_req and rd_req held together over 4 grants -> grant order read, write, read, write; no access lost.
REQ-023 swap_req, then frame_end 10 cycles later -> swap_pending high for those cycles; front_buf 0->1, swap_done one pulse; next write goes to ram_addr=addr+0.
REQ-024 swap_req and frame_end in the same cycle during READ -> swap taken immediately; in-flight read completes from bank 0.
REQ-025 wr_addr=24 (=BUF_SIZE) -> ram_en stays 0, wr_ready pulses; reset asserted during RDATA -> all outputs zero immediately, no rd_valid.
